// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//
// Groups the ID-stage instruction metadata, the data-memory req/ack handshake
// and the pipeline control outputs of pipe_hazard_ctrl.
//
//   master : pipeline side. Drives the ID metadata and dmem_ack, and receives the
//            control outputs.
//   slave  : hazard controller side. The directions are the reverse of master.
//
// Signals
//   id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_write,
//   id_mem_read, id_mem_write, id_branch, id_branch_taken : ID-stage metadata
//   dmem_req / dmem_ack : data-memory access request and completion
//   pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_advance : stall and
//   flush controls
//   fwd_a, fwd_b : EX operand selects (00 regfile, 01 EX_MEM, 10 MEM_WB)
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
   parameter int unsigned REG_AW = 5
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_rs1_used;
   logic              id_rs2_used;
   logic [REG_AW-1:0] id_rd;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              id_mem_write;
   logic              id_branch;
   logic              id_branch_taken;
   logic              dmem_ack;
   logic              dmem_req;
   logic              pc_write;
   logic              if_id_write;
   logic              if_id_flush;
   logic              id_ex_bubble;
   logic              pipe_advance;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
             id_reg_write, id_mem_read, id_mem_write, id_branch, id_branch_taken,
             dmem_ack,
      input  dmem_req, pc_write, if_id_write, if_id_flush, id_ex_bubble,
             pipe_advance, fwd_a, fwd_b
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
             id_reg_write, id_mem_read, id_mem_write, id_branch, id_branch_taken,
             dmem_ack,
      output dmem_req, pc_write, if_id_write, if_id_flush, id_ex_bubble,
             pipe_advance, fwd_a, fwd_b
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard, stall and forwarding controller for the 5-stage core. The block keeps
// its own copy of the EX/MEM/WB destination metadata. From that copy and the
// current ID instruction it produces:
//   - memory-wait stalls, raised while MEM holds an access that has not yet been
//     acknowledged;
//   - load-use stalls and the stalls needed for branch operands resolved in ID,
//     each of which inserts a bubble into EX;
//   - the IF_ID flush for a taken branch or jump;
//   - the EX forwarding selects;
//   - a sticky watchdog for memory waits that run too long.
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   enable      : global run enable; 0 freezes all internal state
//   bus         : pipe_hazard_ctrl_if.slave (ID metadata, dmem handshake, controls)
//   err_timeout : sticky watchdog flag, cleared only by rst
//
// Optional (define PIPE_HAZARD_PERF_CNT_EN)
//   stall_cycles : saturating count of enabled cycles spent in mem_wait or hz
//   flush_count  : saturating count of cycles with if_id_flush asserted
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 16  // at most 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   pipe_hazard_ctrl_if.slave    bus,
`ifdef PIPE_HAZARD_PERF_CNT_EN
   output logic [CNT_W-1:0]     stall_cycles,
   output logic [CNT_W-1:0]     flush_count,
`endif
   output logic                 err_timeout
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_read;
      logic              mem_access;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              rs1_used;
      logic              rs2_used;
   } ex_rec_t;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_read;
      logic              mem_access;
   } mw_rec_t;

   // Per-operand forwarding select. MEM is checked before WB so the younger
   // result wins. A writer never has rd == 0, so x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] rs,
      input logic              used,
      input logic              mem_wr,
      input logic [REG_AW-1:0] mem_rd,
      input logic              wb_wr,
      input logic [REG_AW-1:0] wb_rd
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (used && mem_wr && (mem_rd == rs)) begin
         sel = 2'b01;
      end else if (used && wb_wr && (wb_rd == rs)) begin
         sel = 2'b10;
      end
      return sel;
   endfunction

   ex_rec_t           ex_q, ex_d;
   mw_rec_t           mem_q, mem_d;
   mw_rec_t           wb_q, wb_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              err_q, err_d;

   logic              ex_wr, mem_wr, wb_wr;
   logic              id_hit_ex, id_hit_mem;
   logic              mem_req_raw, mem_wait;
   logic              hz_raw, hz;
   logic              run;

   // Decode of the stage records and the ID operand comparisons
   always_comb begin
      ex_wr  = ex_q.valid  & ex_q.reg_write  & (ex_q.rd  != '0);
      mem_wr = mem_q.valid & mem_q.reg_write & (mem_q.rd != '0);
      wb_wr  = wb_q.valid  & wb_q.reg_write  & (wb_q.rd  != '0);

      id_hit_ex  = (bus.id_rs1_used & (bus.id_rs1 == ex_q.rd)) |
                   (bus.id_rs2_used & (bus.id_rs2 == ex_q.rd));
      id_hit_mem = (bus.id_rs1_used & (bus.id_rs1 == mem_q.rd)) |
                   (bus.id_rs2_used & (bus.id_rs2 == mem_q.rd));

      mem_req_raw = mem_q.valid & mem_q.mem_access;
      mem_wait    = mem_req_raw & ~bus.dmem_ack;

      // A load in EX blocks every consumer. A branch compared in ID also waits
      // for any EX writer and for a load still in MEM.
      hz_raw = bus.id_valid & (
                  (ex_wr & ex_q.mem_read & id_hit_ex) |
                  (bus.id_branch & ex_wr & id_hit_ex) |
                  (bus.id_branch & mem_wr & mem_q.mem_read & id_hit_mem));
      hz     = hz_raw & ~mem_wait;
      run    = ~rst & enable;
   end

   // Control outputs, in priority order: rst, ~enable, mem_wait, hz, flush,
   // normal operation
   always_comb begin
      bus.dmem_req     = 1'b0;
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.if_id_flush  = 1'b0;
      bus.id_ex_bubble = 1'b0;
      bus.pipe_advance = 1'b0;
      if (run) begin
         bus.dmem_req = mem_req_raw;
         if (!mem_wait) begin
            bus.pipe_advance = 1'b1;
            if (hz) begin
               bus.id_ex_bubble = 1'b1;
            end else begin
               bus.pc_write    = 1'b1;
               bus.if_id_write = 1'b1;
               bus.if_id_flush = bus.id_branch_taken & bus.id_valid;
            end
         end
      end
   end

   // Forwarding tracks the EX record even while frozen; only rst forces 00
   always_comb begin
      bus.fwd_a = 2'b00;
      bus.fwd_b = 2'b00;
      if (!rst) begin
         bus.fwd_a = fwd_sel(ex_q.rs1, ex_q.rs1_used, mem_wr, mem_q.rd, wb_wr, wb_q.rd);
         bus.fwd_b = fwd_sel(ex_q.rs2, ex_q.rs2_used, mem_wr, mem_q.rd, wb_wr, wb_q.rd);
      end
   end

   // Next state for the stage records and the watchdog
   always_comb begin
      ex_d       = ex_q;
      mem_d      = mem_q;
      wb_d       = wb_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
      if (enable) begin
         if (bus.pipe_advance) begin
            wb_d  = mem_q;
            mem_d = '{valid:      ex_q.valid,
                      rd:         ex_q.rd,
                      reg_write:  ex_q.reg_write,
                      mem_read:   ex_q.mem_read,
                      mem_access: ex_q.mem_access};
            ex_d  = '{valid:      bus.id_valid & ~hz,
                      rd:         bus.id_rd,
                      reg_write:  bus.id_reg_write,
                      mem_read:   bus.id_mem_read,
                      mem_access: bus.id_mem_read | bus.id_mem_write,
                      rs1:        bus.id_rs1,
                      rs2:        bus.id_rs2,
                      rs1_used:   bus.id_rs1_used,
                      rs2_used:   bus.id_rs2_used};
         end
         if (mem_wait) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
         end else begin
            wait_cnt_d = '0;
         end
         if (mem_wait && (32'(wait_cnt_d) >= TIMEOUT)) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q       <= '0;
         mem_q      <= '0;
         wb_q       <= '0;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         ex_q       <= ex_d;
         mem_q      <= mem_d;
         wb_q       <= wb_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      err_timeout = err_q;
   end

   // The WB copy keeps the full record layout, but only its writer fields are
   // read
   logic unused_wb_meta;
   always_comb begin
      unused_wb_meta = ^{wb_q.mem_read, wb_q.mem_access};
   end

`ifdef PIPE_HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (enable && (mem_wait || hz_raw) && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (bus.if_id_flush && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      stall_cycles = stall_cnt_q;
      flush_count  = flush_cnt_q;
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Scoreboard bench for pipe_hazard_ctrl. For every cycle the driver applies a
// stimulus vector, derives the expected outputs from a reference pipeline of
// three instruction records, and queues them. A monitor compares the queued
// values with the DUT outputs. Directed scenarios run first, then random traffic.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam int unsigned REG_AW  = 5;
   localparam int unsigned TIMEOUT = 8;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   typedef struct packed {
      logic       rst;
      logic       en;
      logic       idv;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       ld;
      logic       st;
      logic       br;
      logic       bt;
      logic       ack;
   } stim_t;

   typedef struct packed {
      logic             dmem_req;
      logic             pc_write;
      logic             if_id_write;
      logic             if_id_flush;
      logic             id_ex_bubble;
      logic             pipe_advance;
      logic [1:0]       fwd_a;
      logic [1:0]       fwd_b;
      logic             err;
      logic [CNT_W-1:0] stall;
      logic [CNT_W-1:0] flush;
   } exp_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
      logic       acc;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
   } rec_t;

   logic clk = 1'b0;
   logic rst;
   logic enable;
   logic err_timeout;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   pipe_hazard_ctrl_if #(.REG_AW(REG_AW)) bus ();

   pipe_hazard_ctrl #(
      .REG_AW  (REG_AW),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .bus          (bus),
`ifdef PIPE_HAZARD_PERF_CNT_EN
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count),
`endif
      .err_timeout  (err_timeout)
   );

`ifndef PIPE_HAZARD_PERF_CNT_EN
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

   always #5 clk = ~clk;

   // Reference model: pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB
   rec_t        pipe [3];
   int unsigned m_cnt;
   bit          m_err;
   int unsigned m_stall;
   int unsigned m_flush;
   int unsigned cycle;

   exp_t exp_q [$];
   int   errors;
   int   checks;

   function automatic bit writer(input rec_t r);
      return r.valid && r.wr && (r.rd != 5'd0);
   endfunction

   function automatic bit reads(input stim_t s, input logic [4:0] r);
      return (s.u1 && (s.rs1 == r)) || (s.u2 && (s.rs2 == r));
   endfunction

   // The younger stage that holds a matching writer gives the select value:
   // stage index 1 (MEM) gives 01 and stage index 2 (WB) gives 10
   function automatic logic [1:0] src(input logic [4:0] rs, input logic used);
      if (!used) return 2'd0;
      for (int k = 1; k <= 2; k++) begin
         if (writer(pipe[k]) && (pipe[k].rd == rs)) return 2'(k);
      end
      return 2'd0;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.en  = 1'b1;
      s.ack = 1'b1;
      return s;
   endfunction

   function automatic stim_t ins(input int rd, input int rs1, input int rs2,
                                 input bit u1, input bit u2, input bit rw,
                                 input bit ld, input bit st, input bit br,
                                 input bit bt);
      stim_t s;
      s = idle();
      s.idv = 1'b1;
      s.rd  = 5'(rd);
      s.rs1 = 5'(rs1);
      s.rs2 = 5'(rs2);
      s.u1  = u1;
      s.u2  = u2;
      s.rw  = rw;
      s.ld  = ld;
      s.st  = st;
      s.br  = br;
      s.bt  = bt;
      return s;
   endfunction

   task automatic step(input stim_t s);
      exp_t e;
      bit   waiting;
      bit   hz;
      bit   adv;
      @(negedge clk);
      rst                 = s.rst;
      enable              = s.en;
      bus.id_valid        = s.idv;
      bus.id_rs1          = s.rs1;
      bus.id_rs2          = s.rs2;
      bus.id_rs1_used     = s.u1;
      bus.id_rs2_used     = s.u2;
      bus.id_rd           = s.rd;
      bus.id_reg_write    = s.rw;
      bus.id_mem_read     = s.ld;
      bus.id_mem_write    = s.st;
      bus.id_branch       = s.br;
      bus.id_branch_taken = s.bt;
      bus.dmem_ack        = s.ack;

      e = '0;
      e.err = m_err;
`ifdef PIPE_HAZARD_PERF_CNT_EN
      e.stall = CNT_W'(m_stall);
      e.flush = CNT_W'(m_flush);
`endif
      waiting = pipe[1].valid && pipe[1].acc && !s.ack;
      hz = s.idv && (
              (writer(pipe[0]) && pipe[0].ld && reads(s, pipe[0].rd)) ||
              (s.br && writer(pipe[0]) && reads(s, pipe[0].rd)) ||
              (s.br && writer(pipe[1]) && pipe[1].ld && reads(s, pipe[1].rd)));
      if (!s.rst) begin
         e.fwd_a = src(pipe[0].rs1, pipe[0].u1);
         e.fwd_b = src(pipe[0].rs2, pipe[0].u2);
      end
      adv = 1'b0;
      if (!s.rst && s.en) begin
         e.dmem_req = pipe[1].valid && pipe[1].acc;
         if (!waiting) begin
            adv            = 1'b1;
            e.pipe_advance = 1'b1;
            if (hz) begin
               e.id_ex_bubble = 1'b1;
            end else begin
               e.pc_write    = 1'b1;
               e.if_id_write = 1'b1;
               e.if_id_flush = s.bt && s.idv;
            end
         end
      end
      exp_q.push_back(e);

      if (s.rst) begin
         for (int k = 0; k < 3; k++) pipe[k] = '0;
         m_cnt   = 0;
         m_err   = 1'b0;
         m_stall = 0;
         m_flush = 0;
      end else if (s.en) begin
         if ((waiting || hz) && m_stall < CNT_MAX) m_stall++;
         if (e.if_id_flush && m_flush < CNT_MAX) m_flush++;
         if (waiting) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (m_cnt >= TIMEOUT) m_err = 1'b1;
         end else begin
            m_cnt = 0;
         end
         if (adv) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{valid: s.idv && !hz, rd: s.rd, wr: s.rw, ld: s.ld,
                        acc: s.ld || s.st, rs1: s.rs1, rs2: s.rs2,
                        u1: s.u1, u2: s.u2};
         end
      end
   endtask

   // Monitor: compares one queued expectation per cycle, mid low phase
   initial begin
      exp_t e;
      exp_t act;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = '{dmem_req: bus.dmem_req, pc_write: bus.pc_write,
                    if_id_write: bus.if_id_write, if_id_flush: bus.if_id_flush,
                    id_ex_bubble: bus.id_ex_bubble, pipe_advance: bus.pipe_advance,
                    fwd_a: bus.fwd_a, fwd_b: bus.fwd_b, err: err_timeout,
                    stall: stall_cycles, flush: flush_count};
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL outputs cycle %0d: got req=%b pcw=%b ifw=%b fl=%b bub=%b adv=%b fa=%b fb=%b err=%b st=%0d fc=%0d, expected req=%b pcw=%b ifw=%b fl=%b bub=%b adv=%b fa=%b fb=%b err=%b st=%0d fc=%0d",
                        cycle, act.dmem_req, act.pc_write, act.if_id_write,
                        act.if_id_flush, act.id_ex_bubble, act.pipe_advance,
                        act.fwd_a, act.fwd_b, act.err, act.stall, act.flush,
                        e.dmem_req, e.pc_write, e.if_id_write, e.if_id_flush,
                        e.id_ex_bubble, e.pipe_advance, e.fwd_a, e.fwd_b, e.err,
                        e.stall, e.flush);
            end
            cycle++;
         end
      end
   end

   initial begin
      stim_t s;
      errors = 0;
      checks = 0;
      cycle  = 0;
      for (int k = 0; k < 3; k++) pipe[k] = '0;
      m_cnt   = 0;
      m_err   = 1'b0;
      m_stall = 0;
      m_flush = 0;
      // Hold reset across the first edge so the DUT state is defined
      s = idle();
      s.rst = 1'b1;
      rst = 1'b1;
      enable = 1'b0;
      bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0;
      bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0; bus.id_rd = '0;
      bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0; bus.id_mem_write = 1'b0;
      bus.id_branch = 1'b0; bus.id_branch_taken = 1'b0; bus.dmem_ack = 1'b1;
      step(s);
      step(s);

      // Load-use: lw x5 ; add x6,x5,x7 with a single-cycle memory
      step(ins(5, 1, 0, 1, 0, 1, 1, 0, 0, 0));
      step(ins(6, 5, 7, 1, 1, 1, 0, 0, 0, 0));
      step(ins(6, 5, 7, 1, 1, 1, 0, 0, 0, 0));
      repeat (3) step(idle());

      // ALU forwarding: add x3 ; sub x4,x3,x3 ; then a writer of x0
      step(ins(3, 1, 2, 1, 1, 1, 0, 0, 0, 0));
      step(ins(4, 3, 3, 1, 1, 1, 0, 0, 0, 0));
      repeat (3) step(idle());
      step(ins(0, 1, 2, 1, 1, 1, 0, 0, 0, 0));
      step(ins(4, 0, 0, 1, 1, 1, 0, 0, 0, 0));
      repeat (3) step(idle());

      // Branch in ID reading x8 while EX writes x8, then resolved taken
      step(ins(8, 1, 2, 1, 1, 1, 0, 0, 0, 0));
      step(ins(0, 8, 9, 1, 1, 0, 0, 0, 1, 0));
      step(ins(0, 8, 9, 1, 1, 0, 0, 0, 1, 1));
      repeat (3) step(idle());

      // Load waits 4 cycles in MEM
      step(ins(10, 1, 0, 1, 0, 1, 1, 0, 0, 0));
      step(ins(11, 10, 0, 1, 0, 1, 0, 0, 0, 0));
      s = idle(); s.ack = 1'b0;
      repeat (4) step(s);
      repeat (3) step(idle());

      // Watchdog: 10 wait cycles, then 20 more to saturate the counter
      step(ins(12, 1, 0, 1, 0, 1, 1, 0, 0, 0));
      step(idle());
      s = idle(); s.ack = 1'b0;
      repeat (10) step(s);
      repeat (2) step(idle());
      step(ins(13, 1, 0, 1, 0, 0, 0, 1, 0, 0));
      step(idle());
      repeat (20) step(s);
      step(idle());

      // Frozen while waiting, then waiting again once re-enabled
      step(ins(14, 1, 0, 1, 0, 1, 1, 0, 0, 0));
      step(ins(15, 14, 14, 1, 1, 1, 0, 0, 1, 1));
      s = idle(); s.ack = 1'b0; s.en = 1'b0;
      repeat (3) step(s);
      s.en = 1'b1;
      repeat (2) step(s);
      repeat (2) step(idle());

      // Reset in the middle of a wait
      step(ins(16, 1, 0, 1, 0, 1, 1, 0, 0, 0));
      step(idle());
      s = idle(); s.ack = 1'b0;
      repeat (3) step(s);
      s.rst = 1'b1;
      step(s);
      repeat (3) step(idle());

      // Random traffic over a small register set so that hazards are frequent
      for (int n = 0; n < 3000; n++) begin
         s = '0;
         s.rst = ($urandom_range(0, 99) == 0);
         s.en  = ($urandom_range(0, 15) != 0);
         s.idv = ($urandom_range(0, 7) != 0);
         s.rs1 = 5'($urandom_range(0, 7));
         s.rs2 = 5'($urandom_range(0, 7));
         s.rd  = 5'($urandom_range(0, 7));
         s.u1  = 1'($urandom);
         s.u2  = 1'($urandom);
         s.ld  = ($urandom_range(0, 3) == 0);
         s.st  = !s.ld && ($urandom_range(0, 5) == 0);
         s.rw  = s.ld || (!s.st && 1'($urandom));
         s.br  = ($urandom_range(0, 4) == 0);
         s.bt  = s.br ? 1'($urandom) : ($urandom_range(0, 9) == 0);
         s.ack = ($urandom_range(0, 2) != 0);
         step(s);
      end

      @(negedge clk);
      #5;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
